fifo_rd_stream: RTL



---
 rtl/fifo_rd_pkg.sv | 17 +
 rtl/fifo_rd_stream_if.sv | 13 +
 rtl/fifo_rd_skid.sv | 60 ++++++
 rtl/fifo_rd_stream.sv | 52 +++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared encodings for the FIFO read-side stream adapter.
// Optional counter width is used only when FIFO_RD_CNT_EN is defined.
package fifo_rd_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int RCOUNT_W = 16;

    typedef enum logic [1:0] {
        CNT_EMPTY = ST_EMPTY,
        CNT_ONE   = ST_ONE,
        CNT_TWO   = ST_TWO
    } cnt_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying words popped from the dual-clock FIFO.
interface fifo_rd_stream_if #(
    parameter int DSIZE = 8
);

    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: out_q is the presented word, skid_q catches the
// word already popped when the consumer stalls.
//
//   state     | meaning
//   ----------+---------------------------------------------
//   CNT_EMPTY | nothing buffered, m_valid low
//   CNT_ONE   | out_q holds the presented word
//   CNT_TWO   | out_q presented, skid_q holds the next word
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             pop,
    input  logic             deq,
    input  logic [DSIZE-1:0] rdata,
    output logic [DSIZE-1:0] out_q,
    output cnt_t             cnt
);

    logic [DSIZE-1:0] skid_q;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            cnt    <= CNT_EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            case (cnt)
                CNT_EMPTY: begin
                    if (pop) begin
                        out_q <= rdata;
                        cnt   <= CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    // out_q keeps its old word when draining to empty
                    if (deq && pop) begin
                        out_q <= rdata;
                    end else if (deq) begin
                        cnt <= CNT_EMPTY;
                    end else if (pop) begin
                        skid_q <= rdata;
                        cnt    <= CNT_TWO;
                    end
                end
                CNT_TWO: begin
                    if (deq) begin
                        out_q <= skid_q;
                        cnt   <= CNT_ONE;
                    end
                end
                default: cnt <= CNT_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side consumer: pops the show-ahead FIFO head and presents it as
// a registered valid/ready stream. FIFO_RD_CNT_EN adds the rcount port.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    fifo_rd_stream_if.master m
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [RCOUNT_W-1:0] rcount
`endif
);

    cnt_t             cnt;
    logic [DSIZE-1:0] out_q;
    logic             deq;

    // Pop depends only on registered occupancy, never on m_ready.
    assign rinc      = !rrst && !rempty && (cnt != CNT_TWO);
    assign m.m_valid = (cnt != CNT_EMPTY);
    assign m.m_data  = out_q;
    assign deq       = m.m_valid && m.m_ready;

    fifo_rd_skid #(
        .DSIZE(DSIZE)
    ) u_skid (
        .rclk  (rclk),
        .rrst  (rrst),
        .pop   (rinc),
        .deq   (deq),
        .rdata (rdata),
        .out_q (out_q),
        .cnt   (cnt)
    );

`ifdef FIFO_RD_CNT_EN
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rcount <= '0;
        end else if (deq) begin
            rcount <= rcount + 1'b1;
        end
    end
`endif

endmodule
